// File: rtl/rect_fill_engine.sv
// Rectangle-fill engine: accepts one fill command, normalises and clips the corners,
// then streams one pixel write per accepted beat in raster order.
module rect_fill_engine #(
  parameter int H_RES   = 640,
  parameter int V_RES   = 480,
  parameter int X_W     = 10,
  parameter int Y_W     = 9,
  parameter int COLOR_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_rts,
  output logic               cmd_rtr,
  input  logic [127:0]       cmd_data,
  output logic               pix_rts,
  input  logic               pix_rtr,
  output logic [X_W-1:0]     pix_x,
  output logic [Y_W-1:0]     pix_y,
  output logic [COLOR_W-1:0] pix_color,
  output logic               busy,
  output logic               done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] FILL = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [15:0] H_RES16 = 16'(H_RES);
  localparam logic [15:0] V_RES16 = 16'(V_RES);
  localparam logic [15:0] X_LAST  = 16'(H_RES - 1);
  localparam logic [15:0] Y_LAST  = 16'(V_RES - 1);

  logic [1:0]         state_q, state_d;
  logic [15:0]        x0_q, x0_d, y0_q, y0_d, x1_q, x1_d, y1_q, y1_d;
  logic [COLOR_W-1:0] color_q, color_d;
  logic [X_W-1:0]     xmin_q, xmin_d, xmax_q, xmax_d;
  logic [Y_W-1:0]     ymax_q, ymax_d;
  logic [X_W-1:0]     pix_x_q, pix_x_d;
  logic [Y_W-1:0]     pix_y_q, pix_y_d;
  logic [COLOR_W-1:0] pix_color_q, pix_color_d;

  logic [15:0] xlo, xhi, ylo, yhi, xhi_clip, yhi_clip;
  logic        empty;

  // Normalised and clipped corners, only consumed in LOAD.
  always_comb begin
    xlo      = (x0_q < x1_q) ? x0_q : x1_q;
    xhi      = (x0_q < x1_q) ? x1_q : x0_q;
    ylo      = (y0_q < y1_q) ? y0_q : y1_q;
    yhi      = (y0_q < y1_q) ? y1_q : y0_q;
    xhi_clip = (xhi > X_LAST) ? X_LAST : xhi;
    yhi_clip = (yhi > Y_LAST) ? Y_LAST : yhi;
    empty    = (xlo >= H_RES16) || (ylo >= V_RES16);
  end

  // NOTE: every next-state signal gets a default first so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    x0_d        = x0_q;
    y0_d        = y0_q;
    x1_d        = x1_q;
    y1_d        = y1_q;
    color_d     = color_q;
    xmin_d      = xmin_q;
    xmax_d      = xmax_q;
    ymax_d      = ymax_q;
    pix_x_d     = pix_x_q;
    pix_y_d     = pix_y_q;
    pix_color_d = pix_color_q;

    case (state_q)
      IDLE: begin
        if (cmd_rts) begin
          x0_d    = cmd_data[15:0];
          y0_d    = cmd_data[31:16];
          x1_d    = cmd_data[47:32];
          y1_d    = cmd_data[63:48];
          color_d = cmd_data[64 +: COLOR_W];
          state_d = LOAD;
        end
      end
      LOAD: begin
        pix_color_d = color_q;
        if (empty) begin
          state_d = DONE;
        end else begin
          xmin_d  = xlo[X_W-1:0];
          xmax_d  = xhi_clip[X_W-1:0];
          ymax_d  = yhi_clip[Y_W-1:0];
          pix_x_d = xlo[X_W-1:0];
          pix_y_d = ylo[Y_W-1:0];
          state_d = FILL;
        end
      end
      FILL: begin
        if (pix_rtr) begin
          if (pix_x_q < xmax_q) begin
            pix_x_d = pix_x_q + 1'b1;
          end else begin
            pix_x_d = xmin_q;
            if (pix_y_q < ymax_q) pix_y_d = pix_y_q + 1'b1;
            else                  state_d = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      x0_q        <= '0;
      y0_q        <= '0;
      x1_q        <= '0;
      y1_q        <= '0;
      color_q     <= '0;
      xmin_q      <= '0;
      xmax_q      <= '0;
      ymax_q      <= '0;
      pix_x_q     <= '0;
      pix_y_q     <= '0;
      pix_color_q <= '0;
    end else begin
      state_q     <= state_d;
      x0_q        <= x0_d;
      y0_q        <= y0_d;
      x1_q        <= x1_d;
      y1_q        <= y1_d;
      color_q     <= color_d;
      xmin_q      <= xmin_d;
      xmax_q      <= xmax_d;
      ymax_q      <= ymax_d;
      pix_x_q     <= pix_x_d;
      pix_y_q     <= pix_y_d;
      pix_color_q <= pix_color_d;
    end
  end

  // Handshake outputs decode the state directly so reset drops them in the same cycle.
  assign cmd_rtr   = (state_q == IDLE) && !rst;
  assign pix_rts   = (state_q == FILL);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign pix_x     = pix_x_q;
  assign pix_y     = pix_y_q;
  assign pix_color = pix_color_q;

endmodule
